pc_source_unit: RTL and testbench
=================================

// Module: pc_source_unit
// PURPOSE
//   Parametrised successor to the 4:1 PC-source mux: owns the registered program counter.
//   Selects the next PC from NSRC packed sources, qualifies the update with PCWrite or
//   PCWriteCond+Zero/BNE, and handles stall, exception redirect, misaligned-target trap and ERET.
//   Sits between the ALU/jump-target logic and the instruction-fetch address of the multicycle CPU.
// PARAMETERS
//   WIDTH         32            PC / source width in bits (>=8)
//   NSRC          4             number of selectable sources (2..8)
//   SELW          2             pc_source width, >= clog2(NSRC)
//   RESET_VECTOR  32'h0000_0000 PC value on reset
//   EXC_VECTOR    32'h0000_0180 PC value on exception / trap
// PORTS
//   clk            in   1            rising-edge clock
//   reset          in   1            asynchronous, active-high reset
//   pc_source      in   SELW         source select; src i = src_bus[i*WIDTH +: WIDTH]
//   src_bus        in   NSRC*WIDTH   packed candidate next-PC values
//   pc_write       in   1            unconditional update strobe
//   pc_write_cond  in   1            conditional (branch) update strobe
//   zero           in   1            ALU zero flag
//   branch_ne      in   1            1: condition is !zero (BNE); 0: zero (BEQ)
//   stall          in   1            freeze PC and all state this cycle
//   exc_req        in   1            external exception request (overflow, illegal op)
//   eret           in   1            return from exception
//   pc             out  WIDTH        registered program counter
//   pc_mux         out  WIDTH        combinational selected source (0 if pc_source >= NSRC)
//   epc            out  WIDTH        PC of the excepting instruction
//   in_exc         out  1            1 while in EXC state
//   fault          out  1            1-cycle pulse: misaligned target or bad select trapped
// BEHAVIOUR
//   - Reset (async, any time, incl. mid-update): pc=RESET_VECTOR, epc=0, in_exc=0, fault=0, state NORM.
//   - take = pc_write | (pc_write_cond & (zero ^ branch_ne)).
//   - bad  = take & ((pc_source >= NSRC) | (pc_mux[1:0] != 2'b00)).
//   - Priority per edge: stall > exc_req > eret > take; only the highest applies.
//   - stall=1: pc, epc, state hold; fault=0; exc_req/eret/take that cycle are dropped (caller re-asserts).
//   - FSM NORM:
//       exc_req                -> pc=EXC_VECTOR, epc=pc, go EXC.
//       else bad               -> pc=EXC_VECTOR, epc=pc, fault=1 for one cycle, go EXC.
//       else take              -> pc=pc_mux (1-edge latency from strobe to pc).
//       eret in NORM           -> ignored (no change).
//   - FSM EXC:
//       exc_req                -> ignored (no nesting); epc preserved.
//       eret                   -> pc=epc, go NORM.
//       else take & !bad       -> pc=pc_mux (handler runs normally).
//       else take & bad        -> pc=EXC_VECTOR, fault=1, epc preserved, stay EXC.
//   - fault deasserts on the next edge unless a new trap occurs.
//   - pc_mux is purely combinational; no arithmetic here (PC+4 arrives on a source).
//   - No update when neither strobe asserted: pc holds.
// TESTING
//   1 reset mid-run: pc=0x40, assert reset async between edges -> pc=0 immediately, in_exc=0, fault=0.
//   2 sources: src0..3=0x4,0x100,0x2000,0x80; pc_write with sel 0..3 -> pc 0x4,0x100,0x2000,0x80 on next edges.
//   3 branch: pc_write_cond=1,zero=1,branch_ne=0,sel=1 -> pc=0x100; zero=1,branch_ne=1 -> pc unchanged.
//   4 trap: pc=0x80, pc_write, sel=0 with src0=0x102 -> pc=0x180, epc=0x80, fault 1 cycle, in_exc=1;
//     then eret -> pc=0x80, in_exc=0.
//   5 priority: stall+exc_req+pc_write same cycle -> no change; next cycle exc_req+pc_write -> pc=0x180.
//   6 nested: in EXC, exc_req -> epc unchanged, pc unchanged; eret in NORM -> ignored.

Source files
------------

// File: rtl/pc_source_unit_if.sv
// Purpose: bundles the PC-source unit's select/strobe inputs and PC/status outputs.
// Ports (signals):
//   pc_source, src_bus                 next-PC select and packed candidates
//   pc_write, pc_write_cond            unconditional / conditional update strobes
//   zero, branch_ne                    branch condition inputs
//   stall, exc_req, eret               freeze, exception request, exception return
//   pc, pc_mux, epc, in_exc, fault     registered PC, selected source, saved PC, status
// master drives the inputs and observes the outputs; slave is the PC unit itself.
interface pc_source_unit_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NSRC  = 4,
   parameter int unsigned SELW  = 2
);
   logic [SELW-1:0]       pc_source;
   logic [NSRC*WIDTH-1:0] src_bus;
   logic                  pc_write;
   logic                  pc_write_cond;
   logic                  zero;
   logic                  branch_ne;
   logic                  stall;
   logic                  exc_req;
   logic                  eret;
   logic [WIDTH-1:0]      pc;
   logic [WIDTH-1:0]      pc_mux;
   logic [WIDTH-1:0]      epc;
   logic                  in_exc;
   logic                  fault;

   modport master (
      output pc_source, src_bus, pc_write, pc_write_cond, zero, branch_ne,
             stall, exc_req, eret,
      input  pc, pc_mux, epc, in_exc, fault
   );

   modport slave (
      input  pc_source, src_bus, pc_write, pc_write_cond, zero, branch_ne,
             stall, exc_req, eret,
      output pc, pc_mux, epc, in_exc, fault
   );
endinterface

// File: rtl/pc_source_unit.sv
// Purpose: owns the registered program counter of the multicycle CPU. Selects the next
//   PC from NSRC packed sources, qualifies the update with pc_write / pc_write_cond,
//   and handles stall, exception redirect, misaligned/bad-select trap and ERET.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    pc_source_unit_if.slave: select, sources, strobes, stall/exc_req/eret in;
//          pc, pc_mux (combinational), epc, in_exc, fault out
module pc_source_unit #(
   parameter int unsigned     WIDTH        = 32,
   parameter int unsigned     NSRC         = 4,
   parameter int unsigned     SELW         = 2,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180)
) (
   input  logic              clk,
   input  logic              reset,
   pc_source_unit_if.slave   bus
);

   typedef enum logic {
      S_NORM = 1'b0,
      S_EXC  = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] pc_q, pc_n;
   logic [WIDTH-1:0] epc_q, epc_n;
   logic             fault_q, fault_n;

   logic [WIDTH-1:0] mux;
   logic             sel_ok;
   logic             take;
   logic             bad;

   // Source select; an out-of-range select yields 0 and is flagged as not ok.
   always_comb begin
      mux    = '0;
      sel_ok = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (bus.pc_source == SELW'(i)) begin
            mux    = bus.src_bus[i*WIDTH +: WIDTH];
            sel_ok = 1'b1;
         end
      end
   end

   // Update qualification; a taken update to a bad target becomes a trap.
   assign take = bus.pc_write | (bus.pc_write_cond & (bus.zero ^ bus.branch_ne));
   assign bad  = take & (~sel_ok | (mux[1:0] != 2'b00));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_NORM;
         pc_q    <= RESET_VECTOR;
         epc_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_n;
         pc_q    <= pc_n;
         epc_q   <= epc_n;
         fault_q <= fault_n;
      end
   end

   // Next state: stall > exc_req > eret > take; only the winning request acts.
   always_comb begin
      state_n = state;
      pc_n    = pc_q;
      epc_n   = epc_q;
      fault_n = 1'b0;
      if (!bus.stall) begin
         case (state)
            S_NORM: begin
               if (bus.exc_req) begin
                  pc_n    = EXC_VECTOR;
                  epc_n   = pc_q;
                  state_n = S_EXC;
               end else if (bus.eret) begin
                  // ERET outside a handler is meaningless and blocks lower requests.
                  pc_n = pc_q;
               end else if (bad) begin
                  pc_n    = EXC_VECTOR;
                  epc_n   = pc_q;
                  fault_n = 1'b1;
                  state_n = S_EXC;
               end else if (take) begin
                  pc_n = mux;
               end
            end
            S_EXC: begin
               if (bus.exc_req) begin
                  // No nesting: the request is swallowed and epc kept intact.
                  pc_n = pc_q;
               end else if (bus.eret) begin
                  pc_n    = epc_q;
                  state_n = S_NORM;
               end else if (bad) begin
                  // A trap inside the handler restarts it but keeps the original epc.
                  pc_n    = EXC_VECTOR;
                  fault_n = 1'b1;
               end else if (take) begin
                  pc_n = mux;
               end
            end
            default: state_n = S_NORM;
         endcase
      end
   end

   assign bus.pc     = pc_q;
   assign bus.pc_mux = mux;
   assign bus.epc    = epc_q;
   assign bus.in_exc = (state == S_EXC);
   assign bus.fault  = fault_q;

endmodule

// File: tb/tb_pc_source_unit.sv
// Scoreboarded bench for pc_source_unit: the driver applies inputs on the falling
// edge and queues the expected post-edge outputs from a behavioural model; the
// monitor pops and compares after every rising edge.
module tb_pc_source_unit;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned NSRC  = 4;
   localparam int unsigned SELW  = 3;
   localparam logic [31:0] EXC_V = 32'h0000_0180;

   logic clk;
   logic reset;

   pc_source_unit_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus ();

   pc_source_unit #(
      .WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW),
      .RESET_VECTOR(32'h0000_0000), .EXC_VECTOR(EXC_V)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] epc;
      logic [31:0] mux;
      logic        in_exc;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   logic [31:0] m_pc  = 32'h0;
   logic [31:0] m_epc = 32'h0;
   logic        m_exc = 1'b0;
   logic        m_fault = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      bus.pc_source     = '0;
      bus.src_bus       = '0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.zero          = 1'b0;
      bus.branch_ne     = 1'b0;
      bus.stall         = 1'b0;
      bus.exc_req       = 1'b0;
      bus.eret          = 1'b0;
   endtask

   task automatic model_reset();
      m_pc    = 32'h0;
      m_epc   = 32'h0;
      m_exc   = 1'b0;
      m_fault = 1'b0;
   endtask

   // Apply one cycle of stimulus and queue what the outputs must be after the next edge.
   task automatic step(input logic [2:0] sel,
                       input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] s3,
                       input logic pw, input logic pwc, input logic z, input logic bne,
                       input logic st, input logic exc, input logic er);
      logic        tk;
      logic        bd;
      logic [31:0] mx;
      logic [31:0] srcs [4];
      exp_t        e;
      @(negedge clk);
      bus.pc_source     = sel;
      bus.src_bus       = {s3, s2, s1, s0};
      bus.pc_write      = pw;
      bus.pc_write_cond = pwc;
      bus.zero          = z;
      bus.branch_ne     = bne;
      bus.stall         = st;
      bus.exc_req       = exc;
      bus.eret          = er;

      srcs[0] = s0; srcs[1] = s1; srcs[2] = s2; srcs[3] = s3;
      mx = (int'(sel) < 4) ? srcs[sel[1:0]] : 32'h0;
      tk = pw || (pwc && (z != bne));
      bd = tk && ((int'(sel) >= 4) || (mx % 4 != 0));

      m_fault = 1'b0;
      if (!st) begin
         if (exc) begin
            if (!m_exc) begin
               m_epc = m_pc;
               m_pc  = EXC_V;
               m_exc = 1'b1;
            end
         end else if (er) begin
            if (m_exc) begin
               m_pc  = m_epc;
               m_exc = 1'b0;
            end
         end else if (bd) begin
            if (!m_exc) m_epc = m_pc;
            m_pc    = EXC_V;
            m_exc   = 1'b1;
            m_fault = 1'b1;
         end else if (tk) begin
            m_pc = mx;
         end
      end

      e.pc     = m_pc;
      e.epc    = m_epc;
      e.mux    = mx;
      e.in_exc = m_exc;
      e.fault  = m_fault;
      exp_q.push_back(e);
   endtask

   // Wait until just after the edge that consumed the last step.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compare queued expectations after every rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_pc",     bus.pc,                e.pc);
            check("sb_epc",    bus.epc,               e.epc);
            check("sb_pc_mux", bus.pc_mux,            e.mux);
            check("sb_in_exc", 32'(bus.in_exc),       32'(e.in_exc));
            check("sb_fault",  32'(bus.fault),        32'(e.fault));
         end
      end
   end

   function automatic logic [31:0] rnd_src();
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
      return v;
   endfunction

   initial begin
      logic [2:0] sel;
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc",     bus.pc,          32'h0);
      check("rst_epc",    bus.epc,         32'h0);
      check("rst_in_exc", 32'(bus.in_exc), 32'h0);
      check("rst_fault",  32'(bus.fault),  32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Reset asserted between edges must clear the PC immediately.
      step(3'd0, 32'h40, 32'h0, 32'h0, 32'h0, 1,0,0,0, 0,0,0);
      settle();
      check("t1_pc_pre", bus.pc, 32'h40);
      #1 reset = 1'b1;
      #1;
      check("t1_async_pc",     bus.pc,          32'h0);
      check("t1_async_in_exc", 32'(bus.in_exc), 32'h0);
      check("t1_async_fault",  32'(bus.fault),  32'h0);
      model_reset();
      idle();
      @(negedge clk);
      reset = 1'b0;

      // Each source selected in turn.
      for (int i = 0; i < 4; i++) begin
         step(3'(i), 32'h4, 32'h100, 32'h2000, 32'h80, 1,0,0,0, 0,0,0);
         settle();
      end
      check("t2_pc_sel3", bus.pc, 32'h80);

      // BEQ taken, then BNE with zero=1 not taken.
      step(3'd1, 32'h4, 32'h100, 32'h2000, 32'h80, 0,1,1,0, 0,0,0);
      settle();
      check("t3_beq_taken", bus.pc, 32'h100);
      step(3'd2, 32'h4, 32'h100, 32'h2000, 32'h80, 0,1,1,1, 0,0,0);
      settle();
      check("t3_bne_not_taken", bus.pc, 32'h100);

      // Misaligned target trap, fault pulse, then ERET.
      step(3'd3, 32'h4, 32'h100, 32'h2000, 32'h80, 1,0,0,0, 0,0,0);
      step(3'd0, 32'h102, 32'h100, 32'h2000, 32'h80, 1,0,0,0, 0,0,0);
      settle();
      check("t4_trap_pc",    bus.pc,          32'h180);
      check("t4_trap_epc",   bus.epc,         32'h80);
      check("t4_trap_fault", 32'(bus.fault),  32'h1);
      step(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0,0,0,0, 0,0,0);
      settle();
      check("t4_fault_clear", 32'(bus.fault), 32'h0);
      step(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0,0,0,0, 0,0,1);
      settle();
      check("t4_eret_pc", bus.pc, 32'h80);

      // Stall beats exception and write; exception beats write next cycle.
      step(3'd1, 32'h4, 32'h100, 32'h2000, 32'h80, 1,0,0,0, 1,1,0);
      settle();
      check("t5_stall_pc", bus.pc, 32'h80);
      step(3'd1, 32'h4, 32'h100, 32'h2000, 32'h80, 1,0,0,0, 0,1,0);
      settle();
      check("t5_exc_pc", bus.pc, 32'h180);

      // No nesting; eret in NORM ignored.
      step(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0,0,0,0, 0,1,0);
      settle();
      check("t6_nest_epc", bus.epc, 32'h80);
      step(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0,0,0,0, 0,0,1);
      step(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0,0,0,0, 0,0,1);
      settle();
      check("t6_eret_norm_pc", bus.pc, 32'h80);

      // Out-of-range select traps; a trap inside the handler keeps epc.
      step(3'd5, 32'h4, 32'h100, 32'h2000, 32'h80, 1,0,0,0, 0,0,0);
      step(3'd0, 32'h102, 32'h100, 32'h2000, 32'h80, 1,0,0,0, 0,0,0);
      settle();
      check("t7_nested_trap_epc", bus.epc, 32'h80);
      step(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0,0,0,0, 0,0,1);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 9) == 0) sel = 3'($urandom_range(4, 7));
         else                           sel = 3'($urandom_range(0, 3));
         step(sel, rnd_src(), rnd_src(), rnd_src(), rnd_src(),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 5) == 0));
      end

      @(posedge clk);
      #3;
      check("sb_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
